// File: rtl/machine_timer.sv
// Memory-mapped machine timer (mtime/mtimecmp) driving mip.MTIP and exporting live mtime.
// Optional build macro MTIME_SNAPSHOT_EN: a 0x0 read latches mtime[63:32] into a shadow returned by 0x4 reads.
module machine_timer #(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [3:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mtip_o,
    output logic [63:0] mtime_o
);

    localparam logic [0:0]  ST_IDLE   = 1'b0;
    localparam logic [0:0]  ST_RESP   = 1'b1;
    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 32'd1);

    logic [0:0]  state_r;
    logic [0:0]  state_next_s;
    logic        ready_r;
    logic        rsp_valid_r;
    logic        rsp_err_r;
    logic [31:0] rsp_rdata_r;
    logic        mtip_r;
    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic [15:0] presc_r;

    logic        accept_s;
    logic        misaligned_s;
    logic        wr_s;
    logic        rd_s;
    logic        tick_s;
    logic        wr_mtime_lo_s;
    logic        wr_mtime_hi_s;
    logic        wr_cmp_lo_s;
    logic        wr_cmp_hi_s;
    logic [31:0] hi_rd_s;
    logic [31:0] rd_data_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

    // Request decode: misaligned accesses are accepted but never touch a register.
    always_comb begin
        accept_s      = req_valid_i && ready_r;
        misaligned_s  = (req_addr_i[1:0] != 2'b00);
        wr_s          = accept_s && req_we_i && !misaligned_s;
        rd_s          = accept_s && !req_we_i && !misaligned_s;
        tick_s        = (presc_r == PRESC_MAX);
        wr_mtime_lo_s = wr_s && (req_addr_i[3:2] == 2'd0);
        wr_mtime_hi_s = wr_s && (req_addr_i[3:2] == 2'd1);
        wr_cmp_lo_s   = wr_s && (req_addr_i[3:2] == 2'd2);
        wr_cmp_hi_s   = wr_s && (req_addr_i[3:2] == 2'd3);
    end

`ifdef MTIME_SNAPSHOT_EN
    logic [31:0] snap_hi_r;

    // Shadow of mtime[63:32] captured at the same instant as a low-word read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_hi_r <= 32'h0000_0000;
        end else if (rd_s && (req_addr_i[3:2] == 2'd0)) begin
            snap_hi_r <= mtime_r[63:32];
        end else begin
            snap_hi_r <= snap_hi_r;
        end
    end

    assign hi_rd_s = snap_hi_r;
`else
    assign hi_rd_s = mtime_r[63:32];
`endif

    // Read mux samples register values before this cycle's update.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (req_addr_i[3:2])
            2'd0:    rd_data_s = mtime_r[31:0];
            2'd1:    rd_data_s = hi_rd_s;
            2'd2:    rd_data_s = mtimecmp_r[31:0];
            2'd3:    rd_data_s = mtimecmp_r[63:32];
            default: rd_data_s = 32'h0000_0000;
        endcase
    end

    // Two-state bus sequencer: IDLE accepts, RESP presents the response.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: state_next_s = accept_s ? ST_RESP : ST_IDLE;
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Bus state and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_next_s;
            ready_r     <= (state_next_s == ST_IDLE);
            rsp_valid_r <= accept_s;
            rsp_err_r   <= accept_s && misaligned_s;
            rsp_rdata_r <= rd_s ? rd_data_s : 32'h0000_0000;
        end
    end

    // Free-running prescaler; keeps counting even when software writes mtime.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= 16'h0000;
        end else if (tick_s) begin
            presc_r <= 16'h0000;
        end else begin
            presc_r <= presc_r + 16'd1;
        end
    end

    // mtime: a software write to either half wins over the tick for that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_r <= 64'h0000_0000_0000_0000;
        end else if (wr_mtime_lo_s) begin
            mtime_r <= {mtime_r[63:32], merge_bytes(mtime_r[31:0], req_wdata_i, req_be_i)};
        end else if (wr_mtime_hi_s) begin
            mtime_r <= {merge_bytes(mtime_r[63:32], req_wdata_i, req_be_i), mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_r <= mtime_r + 64'd1;
        end else begin
            mtime_r <= mtime_r;
        end
    end

    // mtimecmp byte-merged writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp_r <= CMP_RESET;
        end else if (wr_cmp_lo_s) begin
            mtimecmp_r <= {mtimecmp_r[63:32], merge_bytes(mtimecmp_r[31:0], req_wdata_i, req_be_i)};
        end else if (wr_cmp_hi_s) begin
            mtimecmp_r <= {merge_bytes(mtimecmp_r[63:32], req_wdata_i, req_be_i), mtimecmp_r[31:0]};
        end else begin
            mtimecmp_r <= mtimecmp_r;
        end
    end

    // Level-sensitive interrupt, one cycle behind the register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtip_r <= 1'b0;
        end else begin
            mtip_r <= (mtime_r >= mtimecmp_r);
        end
    end

    assign req_ready_o = ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_err_o   = rsp_err_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign mtip_o      = mtip_r;
    assign mtime_o     = mtime_r;

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: scoreboarded bus responses plus a cycle-counted mtime model.
`timescale 1ns/1ps
module tb_machine_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        req_ready, rsp_valid, rsp_err, mtip;
    logic [31:0] rsp_rdata;
    logic [63:0] mtime;
    logic        p4_ready, p4_rsp_valid, p4_rsp_err, p4_mtip;
    logic [31:0] p4_rdata;
    logic [63:0] p4_mtime;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          mt_e0    = 0;
    logic [63:0] mt_x     = 64'h0;

    machine_timer #(.PRESCALE(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .mtip_o(mtip), .mtime_o(mtime)
    );

    machine_timer #(.PRESCALE(4)) dut_p4 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(p4_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .rsp_valid_o(p4_rsp_valid), .rsp_rdata_o(p4_rdata), .rsp_err_o(p4_rsp_err),
        .mtip_o(p4_mtip), .mtime_o(p4_mtime)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected mtime after edge k for PRESCALE=1, since the last software write.
    function automatic logic [63:0] mt_model(input int k);
        return mt_x + 64'(k - mt_e0);
    endfunction

    // One bus transaction from a negedge; acc returns the accept edge index.
    task automatic bus_xfer(input string name, input logic we, input logic [3:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input logic [31:0] exp_rdata, input logic exp_err, output int acc);
        rsp_t exp_r;
        rsp_t got_r;
        int   waits;
        waits = 0;
        while (req_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: got %b want 1 (timeout)", name, req_ready);
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        exp_r.rdata = exp_rdata;
        exp_r.err   = exp_err;
        sb.push_back(exp_r);
        @(negedge clk);
        acc = cyc;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 4'h0; req_wdata = 32'h0; req_be = 4'h0;
        n_checks++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_rsp_valid: got %b want 1", name, rsp_valid);
            sb.delete();
        end else begin
            got_r = sb.pop_front();
            n_checks++;
            if (rsp_rdata !== got_r.rdata || rsp_err !== got_r.err) begin
                n_fail++;
                $display("FAIL %s_rsp: got rdata=%h err=%b want rdata=%h err=%b",
                         name, rsp_rdata, rsp_err, got_r.rdata, got_r.err);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
            rsp_err !== 1'b0 || mtip !== 1'b0 || mtime !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%h e=%b mtip=%b mtime=%h want 0,0,0,0,0,0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, mtip, mtime);
        end
        rst = 1'b0;
    endtask

    task automatic test_prescale();
        int acc;
        repeat (40) @(negedge clk);
        n_checks++;
        if (mtime !== 64'd40) begin
            n_fail++;
            $display("FAIL prescale1_mtime: got %0d want 40", mtime);
        end
        n_checks++;
        if (p4_mtime < 64'd9 || p4_mtime > 64'd11 || p4_mtip !== 1'b0) begin
            n_fail++;
            $display("FAIL prescale4_mtime: got %0d mtip=%b want 10+-1 mtip=0", p4_mtime, p4_mtip);
        end
        bus_xfer("read_cmp_lo_reset", 1'b0, 4'h8, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, acc);
        n_checks++;
        if (p4_rsp_valid !== 1'b1 || p4_rdata !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL p4_read_cmp_lo: got v=%b d=%h want 1 ffffffff", p4_rsp_valid, p4_rdata);
        end
        bus_xfer("read_cmp_hi_reset", 1'b0, 4'hC, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, acc);
    endtask

    task automatic test_wrap();
        int acc;
        bus_xfer("wr_mtime_hi_ones", 1'b1, 4'h4, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, acc);
        bus_xfer("wr_mtime_lo_ones", 1'b1, 4'h0, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, acc);
        n_checks++;
        if (mtime !== 64'hFFFF_FFFF_FFFF_FFFF || mtip !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_allones: got mtime=%h mtip=%b want all-ones 0", mtime, mtip);
        end
        @(negedge clk);
        n_checks++;
        if (mtime !== 64'h0 || mtip !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_zero: got mtime=%h mtip=%b want 0 1", mtime, mtip);
        end
        @(negedge clk);
        n_checks++;
        if (mtime !== 64'h1 || mtip !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_after: got mtime=%h mtip=%b want 1 0", mtime, mtip);
        end
    endtask

    task automatic test_compare();
        int acc;
        bus_xfer("wr_mtime_lo_zero", 1'b1, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0, acc);
        mt_x = 64'h0; mt_e0 = acc;
        bus_xfer("wr_cmp_lo_20", 1'b1, 4'h8, 32'h20, 4'hF, 32'h0, 1'b0, acc);
        bus_xfer("wr_cmp_hi_0", 1'b1, 4'hC, 32'h0, 4'hF, 32'h0, 1'b0, acc);
        while (cyc - mt_e0 < 32) @(negedge clk);
        n_checks++;
        if (mtime !== 64'h20 || mtip !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_at_match: got mtime=%h mtip=%b want 20 0", mtime, mtip);
        end
        @(negedge clk);
        n_checks++;
        if (mtime !== 64'h21 || mtip !== 1'b1) begin
            n_fail++;
            $display("FAIL cmp_rise: got mtime=%h mtip=%b want 21 1", mtime, mtip);
        end
        bus_xfer("wr_cmp_hi_1", 1'b1, 4'hC, 32'h1, 4'hF, 32'h0, 1'b0, acc);
        n_checks++;
        if (mtip !== 1'b1) begin
            n_fail++;
            $display("FAIL cmp_fall_early: got mtip=%b want 1", mtip);
        end
        @(negedge clk);
        n_checks++;
        if (mtip !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_fall: got mtip=%b want 0", mtip);
        end
    endtask

    task automatic test_misaligned();
        int          acc;
        logic [63:0] m;
        bus_xfer("rd_misaligned", 1'b0, 4'h2, 32'h0, 4'h0, 32'h0, 1'b1, acc);
        bus_xfer("wr_misaligned", 1'b1, 4'h6, 32'h1234, 4'hF, 32'h0, 1'b1, acc);
        m = mt_model(cyc);
        n_checks++;
        if (mtime !== m) begin
            n_fail++;
            $display("FAIL misaligned_mtime: got %h want %h", mtime, m);
        end
        bus_xfer("rd_cmp_hi_kept", 1'b0, 4'hC, 32'h0, 4'h0, 32'h1, 1'b0, acc);
        bus_xfer("rd_cmp_lo_kept", 1'b0, 4'h8, 32'h0, 4'h0, 32'h20, 1'b0, acc);
        @(negedge clk);
        m = mt_model(cyc);
        bus_xfer("rd_mtime_lo", 1'b0, 4'h0, 32'h0, 4'h0, m[31:0], 1'b0, acc);
    endtask

    task automatic test_byte_enable();
        int          acc;
        logic [63:0] m;
        bus_xfer("wr_cmp_lo_be2", 1'b1, 4'h8, 32'hAABB_CCDD, 4'b0010, 32'h0, 1'b0, acc);
        bus_xfer("wr_cmp_hi_be0", 1'b1, 4'hC, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, acc);
        bus_xfer("rd_cmp_lo_merged", 1'b0, 4'h8, 32'h0, 4'h0, 32'h0000_CC20, 1'b0, acc);
        bus_xfer("rd_cmp_hi_noop", 1'b0, 4'hC, 32'h0, 4'h0, 32'h1, 1'b0, acc);
        @(negedge clk);
        m = mt_model(cyc);
        m = {m[63:8], 8'h55};
        bus_xfer("wr_mtime_lo_be1", 1'b1, 4'h0, 32'hA5A5_A555, 4'b0001, 32'h0, 1'b0, acc);
        n_checks++;
        if (mtime !== m) begin
            n_fail++;
            $display("FAIL collision_lo: got %h want %h", mtime, m);
        end
        mt_x = m; mt_e0 = acc;
        @(negedge clk);
        m = mt_model(cyc);
        m = {8'h7F, m[55:0]};
        bus_xfer("wr_mtime_hi_be8", 1'b1, 4'h4, 32'h7F00_0000, 4'b1000, 32'h0, 1'b0, acc);
        n_checks++;
        if (mtime !== m) begin
            n_fail++;
            $display("FAIL collision_hi: got %h want %h", mtime, m);
        end
        mt_x = m; mt_e0 = acc;
        @(negedge clk);
        n_checks++;
        if (mtime !== m + 64'd1) begin
            n_fail++;
            $display("FAIL collision_resume: got %h want %h", mtime, m + 64'd1);
        end
    endtask

    task automatic test_back_to_back();
        rsp_t exp_r;
        rsp_t got_r;
        exp_r.rdata = 32'h0000_CC20;
        exp_r.err   = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h8; req_be = 4'h0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (req_ready !== 1'(i % 2 == 0)) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b want %b", i, req_ready, 1'(i % 2 == 0));
            end
            if (req_ready === 1'b1) sb.push_back(exp_r);
            n_checks++;
            if (rsp_valid !== 1'(i % 2 == 1)) begin
                n_fail++;
                $display("FAIL b2b_rsp_valid[%0d]: got %b want %b", i, rsp_valid, 1'(i % 2 == 1));
            end
            if (rsp_valid === 1'b1 && sb.size() > 0) begin
                got_r = sb.pop_front();
                n_checks++;
                if (rsp_rdata !== got_r.rdata || rsp_err !== got_r.err) begin
                    n_fail++;
                    $display("FAIL b2b_rsp[%0d]: got %h/%b want %h/%b", i, rsp_rdata, rsp_err,
                             got_r.rdata, got_r.err);
                end
            end
            if (i == 7) req_valid = 1'b0;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_pending: got %0d outstanding want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        bus_xfer("wr_cmp_lo_0", 1'b1, 4'h8, 32'h0, 4'hF, 32'h0, 1'b0, acc);
        bus_xfer("wr_cmp_hi_0b", 1'b1, 4'hC, 32'h0, 4'hF, 32'h0, 1'b0, acc);
        @(negedge clk);
        n_checks++;
        if (mtip !== 1'b1 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got mtip=%b rdy=%b want 1 1", mtip, req_ready);
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'hC;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_resp: got rsp_valid=%b want 1", rsp_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b0 ||
            mtip !== 1'b0 || mtime !== 64'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b d=%h e=%b rdy=%b mtip=%b mtime=%h want all 0",
                     rsp_valid, rsp_rdata, rsp_err, req_ready, mtip, mtime);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL dropped_rsp[%0d]: got rsp_valid=%b want 0", i, rsp_valid);
            end
        end
    endtask

    task automatic test_snapshot();
        int          acc;
        logic [63:0] m;
        logic [31:0] exp_hi;
`ifdef MTIME_SNAPSHOT_EN
        exp_hi = 32'h0000_0000;
`else
        exp_hi = 32'h0000_0001;
`endif
        bus_xfer("wr_mtime_lo_fff0", 1'b1, 4'h0, 32'hFFFF_FFF0, 4'hF, 32'h0, 1'b0, acc);
        mt_x = 64'h0000_0000_FFFF_FFF0; mt_e0 = acc;
        while (cyc < mt_e0 + 15) @(negedge clk);
        m = mt_model(cyc);
        bus_xfer("rd_snap_lo", 1'b0, 4'h0, 32'h0, 4'h0, m[31:0], 1'b0, acc);
        n_checks++;
        if (m !== 64'h0000_0000_FFFF_FFFF || mtime[63:32] !== 32'h1) begin
            n_fail++;
            $display("FAIL snap_setup: got model=%h live_hi=%h want ffffffff 1", m, mtime[63:32]);
        end
        bus_xfer("rd_snap_hi", 1'b0, 4'h4, 32'h0, 4'h0, exp_hi, 1'b0, acc);
        bus_xfer("rd_snap_hi_again", 1'b0, 4'h4, 32'h0, 4'h0, exp_hi, 1'b0, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 4'h0; req_wdata = 32'h0; req_be = 4'h0;
        test_reset();
        test_prescale();
        test_wrap();
        test_compare();
        test_misaligned();
        test_byte_enable();
        test_back_to_back();
        test_reset_mid();
        test_snapshot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
